dds_phase_to_sine: RTL and testbench
====================================

// Module: dds_phase_to_sine
// PURPOSE
//  Consumer end of the chirp FTW interface: integrates the per-sample FTW into a
//  phase accumulator and converts phase to a signed sine sample via a quarter-wave
//  ROM. Sits directly downstream of the chirp frequency accumulator; together they
//  form the LFM DDS. Three-stage pipeline with valid tracking and a sync phase clear.
// PARAMETERS
//  N    32  FTW / phase accumulator width (phase modulo 2^N)
//  PW   12  phase bits to the sine lookup (2 quadrant bits + PW-2 ROM address bits)
//  AW   16  signed output amplitude width
// PORTS
//  clk        in   1     clock
//  rst        in   1     reset, asynchronous, active-high
//  en         in   1     sample strobe: accumulate and launch one sample this cycle
//  phase_clr  in   1     synchronous clear of the phase accumulator
//  ftw_in     in   N     frequency tuning word, sampled on cycles with en=1
//  phase_off  in   N     static phase offset added before lookup, sampled with en
//  phase_out  out  N     current phase accumulator value
//  sin_out    out  AW    signed sine sample
//  sin_valid  out  1     sin_out holds a new sample this cycle
// BEHAVIOUR
//  - Reset: phase_acc, all pipeline regs, phase_out, sin_out = 0; sin_valid = 0.
//  - Accumulator (cycle k, en=1): p = phase_clr ? 0 : phase_acc;
//    phase_acc <= p + ftw_in (mod 2^N). en=0: phase_acc <= phase_clr ? 0 : phase_acc.
//    phase_out = phase_acc (registered, no extra delay).
//  - Stage 1 (edge ending cycle k): s1_ph <= p + phase_off (mod 2^N); s1_v <= en.
//    The sample launched at k uses pre-update phase: first sample after clear = phase_off.
//  - Stage 2: q = s1_ph[N-1:N-2]; a = s1_ph[N-3:N-PW];
//    addr = q[0] ? ~a : a; s2_rom <= ROM[addr]; s2_neg <= q[1]; s2_v <= s1_v.
//  - Stage 3: sin_out <= s2_neg ? -s2_rom : s2_rom; sin_valid <= s2_v.
//    sin_out holds its value while sin_valid=0.
//  - Latency: en at cycle k -> sin_valid high in cycle k+3. Back-to-back en gives one
//    sample per clock; gaps in en propagate as gaps in sin_valid.
//  - ROM: 2^(PW-2) entries, unsigned AW-1 bits, built at elaboration:
//    ROM[i] = round((2^(AW-1)-1) * sin(2*pi*(i+0.5)/2^PW)). The half-LSB offset makes
//    the ~a fold exactly symmetric; no entry is 0 or full-scale overflow, negation
//    never overflows.
//  - Truncation of phase below bit N-PW; no dithering.
//  - phase_clr and en together: clear wins for the launched sample (phase 0),
//    phase_acc <= ftw_in. phase_clr does not flush the pipeline.
//  - ftw_in changes only take effect on en cycles; ftw=0 yields a constant sample.
//  - Async reset mid-stream: pipeline dropped, no sin_valid until 3 cycles after next en.
// TESTING
//  1 Assert rst mid-run -> phase_out=0, sin_out=0, sin_valid=0 immediately; hold while rst.
//  2 PW=12,AW=16: phase_clr+en, ftw=2^30, off=0, en held -> sin_out 25,32767,-25,-32767
//    repeating, first sin_valid 3 cycles after first en.
//  3 ftw=0, off=2^30, clear then en held -> sin_out constant 32767; phase_out stays 0.
//  4 Wrap: clear, ftw=2^32-2^30 (=-fs/4) -> sequence 25,-32767,-25,32767; phase_out
//    0xC0000000 after first step, no X/overflow.
//  5 en pattern 1,0,0,1,1 -> sin_valid pattern same shifted by 3; phase_acc advances 3x
//    ftw only; samples match cycle-model.
//  6 Random ftw/off/en/clr 10k cycles vs bit-accurate reference model -> exact match of
//    sin_out, sin_valid, phase_out every cycle.

Source files
------------

// File: rtl/dds_phase_to_sine.sv
// Phase accumulator plus quarter-wave sine lookup for the LFM DDS.
// The FTW is integrated every sample strobe. The pre-update phase plus the
// offset is truncated to PW bits and folded into one quadrant for the ROM.
// The result is sign-restored three clock edges after the strobe.
module dds_phase_to_sine #(
   parameter int N  = 32,
   parameter int PW = 12,
   parameter int AW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 phase_clr,
   input  logic [N-1:0]         ftw_in,
   input  logic [N-1:0]         phase_off,
   output logic [N-1:0]         phase_out,
   output logic signed [AW-1:0] sin_out,
   output logic                 sin_valid
);

   localparam int  DEPTH = 2 ** (PW - 2);
   localparam real PI    = 3.14159265358979323846;

   // Odd-power series. The argument never exceeds pi/2, so truncation error
   // stays far below the rounding granularity.
   function automatic real sin_series(input real x);
      real term;
      real sum;
      term = x;
      sum  = x;
      for (int k = 1; k < 14; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         sum  = sum + term;
      end
      return sum;
   endfunction

   // Entries are centred half an LSB into each phase bin. This makes the
   // ~a fold mirror exactly about the quadrant midpoint.
   function automatic logic [AW-2:0] rom_entry(input int i);
      real amp;
      int  v;
      amp = ((2.0 ** (AW - 1)) - 1.0) *
            sin_series(2.0 * PI * (real'(i) + 0.5) / (2.0 ** PW));
      v = $rtoi(amp + 0.5);
      return v[AW-2:0];
   endfunction

   logic [AW-2:0] rom [0:DEPTH-1];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam logic [AW-2:0] ROM_V = rom_entry(gi);
      assign rom[gi] = ROM_V;
   end

   logic [N-1:0]         phase_acc_q, phase_acc_d;
   logic [N-1:0]         p_base;
   logic [PW-1:0]        s1_ph_q, s1_ph_d;
   logic                 s1_v_q;
   logic [AW-2:0]        s2_rom_q;
   logic                 s2_neg_q;
   logic                 s2_v_q;
   logic [PW-3:0]        rom_addr;
   logic signed [AW-1:0] sin_q, sin_d;
   logic                 sin_valid_q;

   // Accumulator next state. A clear rebases the launched sample to phase zero.
   always_comb begin
      p_base      = phase_clr ? '0 : phase_acc_q;
      phase_acc_d = en ? p_base + ftw_in : p_base;
      s1_ph_d     = PW'((p_base + phase_off) >> (N - PW));
   end

   // Quadrant fold. Odd quadrants read the table mirrored, and the upper
   // half-cycle is negated at the output.
   always_comb begin
      rom_addr = s1_ph_q[PW-3:0];
      if (s1_ph_q[PW-2]) begin
         rom_addr = ~s1_ph_q[PW-3:0];
      end
   end

   // Sign restoration. The table never holds full scale, so negation cannot overflow.
   always_comb begin
      sin_d = $signed({1'b0, s2_rom_q});
      if (s2_neg_q) begin
         sin_d = -$signed({1'b0, s2_rom_q});
      end
   end

   // Phase accumulator and three pipeline stages with valid tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_acc_q <= '0;
         s1_ph_q     <= '0;
         s1_v_q      <= 1'b0;
         s2_rom_q    <= '0;
         s2_neg_q    <= 1'b0;
         s2_v_q      <= 1'b0;
         sin_q       <= '0;
         sin_valid_q <= 1'b0;
      end else begin
         phase_acc_q <= phase_acc_d;
         s1_v_q      <= en;
         if (en) begin
            s1_ph_q <= s1_ph_d;
         end
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_rom_q <= rom[rom_addr];
            s2_neg_q <= s1_ph_q[PW-1];
         end
         sin_valid_q <= s2_v_q;
         if (s2_v_q) begin
            sin_q <= sin_d;
         end
      end
   end

   assign phase_out = phase_acc_q;
   assign sin_out   = sin_q;
   assign sin_valid = sin_valid_q;

endmodule

// File: tb/tb_dds_phase_to_sine.sv
// Self-checking bench for dds_phase_to_sine.
// The reference is written from the sine definition directly: it keeps a phase
// accumulator and a queue of (due cycle, expected sample) pairs.
`timescale 1ns/1ps
module tb_dds_phase_to_sine;

   localparam real PI = 3.14159265358979323846;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic               phase_clr = 1'b0;
   logic [31:0]        ftw_in = '0;
   logic [31:0]        phase_off = '0;
   logic [31:0]        phase_out;
   logic signed [15:0] sin_out;
   logic               sin_valid;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_acc = '0;
   int          m_sin = 0;
   int          q_due[$];
   int          q_val[$];
   int          seen[$];
   int          cyc = 0;

   dds_phase_to_sine #(.N(32), .PW(12), .AW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .phase_clr (phase_clr),
      .ftw_in    (ftw_in),
      .phase_off (phase_off),
      .phase_out (phase_out),
      .sin_out   (sin_out),
      .sin_valid (sin_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Ideal sample for a phase: half-bin-centred sine of the top 12 phase bits,
   // rounded half away from zero.
   function automatic int ref_sine(input logic [31:0] ph);
      int  idx;
      real r;
      idx = int'(ph >> 20);
      r = 32767.0 * $sin(2.0 * PI * (real'(idx) + 0.5) / 4096.0);
      if (r >= 0.0) return $rtoi(r + 0.5);
      return -$rtoi(-r + 0.5);
   endfunction

   task automatic step(input logic e, input logic c, input logic [31:0] f, input logic [31:0] o);
      logic [31:0] p;
      logic        exp_v;
      en        = e;
      phase_clr = c;
      ftw_in    = f;
      phase_off = o;
      p = c ? 32'd0 : m_acc;
      if (e) begin
         q_due.push_back(cyc + 3);
         q_val.push_back(ref_sine(p + o));
         m_acc = p + f;
      end else begin
         m_acc = p;
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_v = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         exp_v = 1'b1;
         m_sin = q_val.pop_front();
         void'(q_due.pop_front());
      end
      check("phase_out", longint'(phase_out), longint'(m_acc));
      check("sin_valid", longint'(sin_valid), longint'(exp_v));
      check("sin_out", longint'(sin_out), longint'(m_sin));
      if (sin_valid) seen.push_back(int'(sin_out));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_phase"}, longint'(phase_out), 0);
      check({tag, "_sin"}, longint'(sin_out), 0);
      check({tag, "_valid"}, longint'(sin_valid), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_reset_state("rst_now");
      repeat (2) @(posedge clk);
      #1;
      cyc += 2;
      check_reset_state("rst_hold");
      m_acc = '0;
      m_sin = 0;
      q_due.delete();
      q_val.delete();
      rst = 1'b0;
   endtask

   task automatic drain();
      repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0);
      seen.delete();
   endtask

   initial begin
      int          pat2[4];
      int          pat4[4];
      int          first_step;
      logic [7:0]  vmask;
      logic        e5[8];
      logic [31:0] f5;

      pat2 = '{25, 32767, -25, -32767};
      pat4 = '{25, -32767, -25, 32767};
      e5   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check_reset_state("init");
      rst = 1'b0;

      // Quarter-rate tone from a cleared phase.
      first_step = -1;
      step(1'b1, 1'b1, 32'h4000_0000, 32'd0);
      for (int i = 2; i <= 12; i++) begin
         step(1'b1, 1'b0, 32'h4000_0000, 32'd0);
         if (first_step < 0 && seen.size() > 0) first_step = i;
      end
      check("t2_first_valid_step", first_step, 3);
      for (int i = 0; i < 8; i++) check("t2_seq", seen[i], pat2[i % 4]);
      $display("t2 quarter-rate tone: %0d samples", seen.size());

      // Mid-stream reset with a full pipeline.
      do_reset();
      $display("t1 reset mid-stream");

      // Zero FTW with a quarter-cycle offset gives a constant peak.
      drain();
      step(1'b1, 1'b1, 32'd0, 32'h4000_0000);
      repeat (7) step(1'b1, 1'b0, 32'd0, 32'h4000_0000);
      check("t3_phase", longint'(phase_out), 0);
      for (int i = 0; i < seen.size(); i++) check("t3_const", seen[i], 32767);
      $display("t3 zero ftw: %0d samples", seen.size());

      // Negative frequency wraps the accumulator downward.
      drain();
      step(1'b1, 1'b1, 32'hC000_0000, 32'd0);
      check("t4_phase_first", longint'(phase_out), longint'(32'hC000_0000));
      repeat (9) step(1'b1, 1'b0, 32'hC000_0000, 32'd0);
      for (int i = 0; i < 8; i++) check("t4_seq", seen[i], pat4[i % 4]);
      $display("t4 negative ftw: %0d samples", seen.size());

      // Gapped strobes: the valid pattern tracks en three edges later.
      drain();
      f5 = 32'h0123_4567;
      step(1'b0, 1'b1, 32'd0, 32'd0);
      vmask = '0;
      for (int i = 0; i < 8; i++) begin
         step(e5[i], 1'b0, f5, 32'h1000_0000);
         vmask[i] = sin_valid;
      end
      check("t5_valid_mask", longint'(vmask), longint'(8'b0110_0100));
      check("t5_phase", longint'(phase_out), longint'(f5 * 32'd3));
      $display("t5 gapped strobes: mask=%b", vmask);

      // Random traffic with one reset in the middle.
      drain();
      for (int i = 0; i < 10000; i++) begin
         logic [31:0] rf;
         if (i == 5000) do_reset();
         rf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom;
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rf, $urandom);
      end
      $display("t6 random: %0d cycles", 10000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
